// File: rtl/wb_mem16x16_bridge.sv
// wb_mem16x16_bridge
//
// Wishbone classic slave in front of the 16x16 DFF memory macro. A bus
// cycle that hits the slave window becomes a short sequence of macro
// strobes. Read data comes back with a single-cycle ack. Byte-partial
// writes are done as read-modify-write, so the macro only ever sees
// full 16-bit words.
//
// Optional build macro:
//   WB_MEM_ERR_EN - adds wbs_err_o. An out-of-range hit then raises err
//                   instead of ack, with the same timing.
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   wbs_cyc_i  WB cycle
//   wbs_stb_i  WB strobe
//   wbs_we_i   WB write enable
//   wbs_sel_i  byte selects; only [1:0] are meaningful
//   wbs_adr_i  byte address
//   wbs_dat_i  write data; [15:0] used
//   wbs_dat_o  read data; [31:16] always zero
//   wbs_ack_o  transfer acknowledge
//   wbs_err_o  error pulse for out-of-range hits (WB_MEM_ERR_EN only)
//   mem_cs     macro chip select
//   mem_we     macro write enable
//   mem_addr   macro word address; [11:4] stay zero
//   mem_din    macro write data
//   mem_dout   macro combinational read data
module wb_mem16x16_bridge #(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int          WIN_BITS  = 8,
  parameter int          DEPTH     = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic [31:0] wbs_dat_o,
  output logic        wbs_ack_o,
`ifdef WB_MEM_ERR_EN
  output logic        wbs_err_o,
`endif
  output logic        mem_cs,
  output logic        mem_we,
  output logic [11:0] mem_addr,
  output logic [15:0] mem_din,
  input  logic [15:0] mem_dout
);

  localparam int IW = WIN_BITS - 2;

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] RD   = 3'd1;
  localparam logic [2:0] RMW  = 3'd2;
  localparam logic [2:0] WR   = 3'd3;
  localparam logic [2:0] ACK  = 3'd4;

  logic [2:0]    state;
  logic [1:0]    sel_q;
  logic [IW-1:0] index;
  logic          hit;
  logic          req;
  logic          in_range;
  logic          unused_bits;

  assign index    = wbs_adr_i[WIN_BITS-1:2];
  assign hit      = (wbs_adr_i[31:WIN_BITS] == BASE_ADDR[31:WIN_BITS]);
  assign req      = wbs_cyc_i & wbs_stb_i & hit;
  assign in_range = (32'(index) < 32'(DEPTH));

  // Bus bits the 16-bit word interface never looks at.
  assign unused_bits = ^{wbs_adr_i[1:0], wbs_sel_i[3:2], wbs_dat_i[31:16]};

  // Transaction sequencer. mem_addr/mem_din change only when a request
  // is accepted. They stay stable through WR and ACK, so the macro's
  // gated write clock sees steady data when mem_we falls.
  // In RMW the macro is read for one cycle. Byte lanes the master did
  // not select are then refilled from the old word before the WR cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      sel_q     <= 2'b00;
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= 32'h0;
`ifdef WB_MEM_ERR_EN
      wbs_err_o <= 1'b0;
`endif
      mem_cs    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 12'h0;
      mem_din   <= 16'h0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            sel_q <= wbs_sel_i[1:0];
            if (in_range) begin
              mem_addr <= 12'(index);
              mem_din  <= wbs_dat_i[15:0];
              if (!wbs_we_i) begin
                state  <= RD;
                mem_cs <= 1'b1;
              end else begin
                case (wbs_sel_i[1:0])
                  2'b11: begin
                    state  <= WR;
                    mem_cs <= 1'b1;
                    mem_we <= 1'b1;
                  end
                  2'b00: begin
                    state     <= ACK;
                    wbs_ack_o <= 1'b1;
                  end
                  default: begin
                    state  <= RMW;
                    mem_cs <= 1'b1;
                  end
                endcase
              end
            end else begin
              // Hit inside the window but past the implemented words.
              state <= ACK;
              if (!wbs_we_i) begin
                wbs_dat_o <= 32'h0;
              end
`ifdef WB_MEM_ERR_EN
              wbs_err_o <= 1'b1;
`else
              wbs_ack_o <= 1'b1;
`endif
            end
          end
        end
        RD: begin
          wbs_dat_o <= {16'h0, mem_dout};
          mem_cs    <= 1'b0;
          wbs_ack_o <= 1'b1;
          state     <= ACK;
        end
        RMW: begin
          mem_din[7:0]  <= sel_q[0] ? mem_din[7:0]  : mem_dout[7:0];
          mem_din[15:8] <= sel_q[1] ? mem_din[15:8] : mem_dout[15:8];
          mem_we        <= 1'b1;
          state         <= WR;
        end
        WR: begin
          mem_cs    <= 1'b0;
          mem_we    <= 1'b0;
          wbs_ack_o <= 1'b1;
          state     <= ACK;
        end
        ACK: begin
          wbs_ack_o <= 1'b0;
`ifdef WB_MEM_ERR_EN
          wbs_err_o <= 1'b0;
`endif
          state     <= IDLE;
        end
        default: begin
          mem_cs    <= 1'b0;
          mem_we    <= 1'b0;
          wbs_ack_o <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
